photon_bcd_counter: RTL and testbench

Gated photon-pulse counter that sits directly upstream of the OLED display controller. Synchronises the raw detector pulse and counts rising edges in an 8-digit BCD accumulator over a fixed gate window. At window close it latches the count into char0..char7. Those outputs feed the controller's char0..char7 inputs without further conversion.

---
 rtl/photon_bcd_counter.sv | 171 +++++++++++++++++
 tb/tb_photon_bcd_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/photon_bcd_counter.sv
// photon_bcd_counter: gated photon-pulse counter feeding the OLED display controller.
// It synchronises the raw detector pulse and counts its rising edges in an
// 8-digit BCD accumulator. At the end of each gate window it latches the
// count onto char0..char7, with char0 as the least significant digit.
// Optional feature macro: PHOTON_OVF_FLAG_EN. When it is defined, ovf reports
// whether an edge arrived while the accumulator was already at 99999999
// during the last latched window.
module photon_bcd_counter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned GATE_W      = 26,
    parameter bit          SATURATE    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pulse_in,
    input  logic       clr,
    output logic [3:0] char0,
    output logic [3:0] char1,
    output logic [3:0] char2,
    output logic [3:0] char3,
    output logic [3:0] char4,
    output logic [3:0] char5,
    output logic [3:0] char6,
    output logic [3:0] char7,
    output logic       latch_stb,
    output logic       ovf
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [31:0]       ACC_MAX   = 32'h9999_9999;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              count_active;

    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              edge_q;

    logic [GATE_W-1:0] gate_cnt;
    logic [31:0]       acc;
    logic [31:0]       acc_inc;
    logic [31:0]       acc_next_val;
    logic [31:0]       char_reg;
    logic              bcd_carry;
    logic              at_max;
    logic              do_inc;
    logic              window_close;

    // Two-flop synchroniser, history flop, and registered rising-edge detect; runs regardless of en
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= pulse_in;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;
        end
    end

    // Run/idle state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: follow en; counting is active whenever the machine is (or enters) RUN
    always_comb begin
        next_state   = state;
        count_active = 1'b0;
        case (state)
            IDLE:    if (en)  next_state = RUN;
            RUN:     if (!en) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        count_active = (next_state == RUN);
    end

    // Single-cycle BCD ripple increment: a 9 rolls to 0 and carries into the next digit
    always_comb begin
        acc_inc   = acc;
        bcd_carry = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bcd_carry) begin
                if (acc[i*4 +: 4] == 4'd9) begin
                    acc_inc[i*4 +: 4] = 4'd0;
                end else begin
                    acc_inc[i*4 +: 4] = acc[i*4 +: 4] + 4'd1;
                    bcd_carry         = 1'b0;
                end
            end
        end
    end

    assign at_max       = (acc == ACC_MAX);
    assign do_inc       = edge_q && count_active;
    assign window_close = count_active && (gate_cnt == GATE_LAST);
    assign acc_next_val = (do_inc && !(SATURATE && at_max)) ? acc_inc : acc;

    // Gate counter, accumulator and latched digits; the clear takes precedence over window close
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt  <= '0;
            acc       <= '0;
            char_reg  <= '0;
            latch_stb <= 1'b0;
        end else if (clr) begin
            gate_cnt  <= '0;
            acc       <= '0;
            char_reg  <= '0;
            latch_stb <= 1'b0;
        end else begin
            latch_stb <= 1'b0;
            if (window_close) begin
                gate_cnt  <= '0;
                acc       <= '0;
                char_reg  <= acc_next_val;
                latch_stb <= 1'b1;
            end else if (count_active) begin
                gate_cnt <= gate_cnt + 1'b1;
                acc      <= acc_next_val;
            end
        end
    end

    assign char0 = char_reg[3:0];
    assign char1 = char_reg[7:4];
    assign char2 = char_reg[11:8];
    assign char3 = char_reg[15:12];
    assign char4 = char_reg[19:16];
    assign char5 = char_reg[23:20];
    assign char6 = char_reg[27:24];
    assign char7 = char_reg[31:28];

`ifdef PHOTON_OVF_FLAG_EN
    logic ovf_acc;
    logic ovf_hit;

    assign ovf_hit = do_inc && at_max;

    // Sticky in-window overflow, transferred to ovf at window close together with any same-cycle hit
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ovf_acc <= 1'b0;
            ovf     <= 1'b0;
        end else if (window_close) begin
            ovf     <= ovf_acc | ovf_hit;
            ovf_acc <= 1'b0;
        end else if (ovf_hit) begin
            ovf_acc <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_photon_bcd_counter.sv
// Testbench for photon_bcd_counter. It runs a saturating and a wrapping
// instance side by side on the same inputs. Expected latches are queued as
// stimulus is planned, and they are checked whenever latch_stb fires.
module tb_photon_bcd_counter;

    localparam int G = 320;

`ifdef PHOTON_OVF_FLAG_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    typedef struct {
        int          cycle;
        logic [31:0] sat_val;
        logic [31:0] wrap_val;
        logic        ovf_val;
    } exp_t;

    logic clk;
    logic rst;
    logic en;
    logic pulse_in;
    logic clr;

    logic [3:0] s0, s1, s2, s3, s4, s5, s6, s7;
    logic [3:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic       stb_s, stb_w, ovf_s, ovf_w;
    logic [31:0] chars_s, chars_w;

    int   cyc = 0;
    int   base = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    assign chars_s = {s7, s6, s5, s4, s3, s2, s1, s0};
    assign chars_w = {w7, w6, w5, w4, w3, w2, w1, w0};

    photon_bcd_counter #(.GATE_CYCLES(G), .GATE_W(10), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in), .clr(clr),
        .char0(s0), .char1(s1), .char2(s2), .char3(s3),
        .char4(s4), .char5(s5), .char6(s6), .char7(s7),
        .latch_stb(stb_s), .ovf(ovf_s)
    );

    photon_bcd_counter #(.GATE_CYCLES(G), .GATE_W(10), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in), .clr(clr),
        .char0(w0), .char1(w1), .char2(w2), .char3(w3),
        .char4(w4), .char5(w5), .char6(w6), .char7(w7),
        .latch_stb(stb_w), .ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count used to time-stamp strobes
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic waitUntil(input int t);
        while (cyc - base < t) @(negedge clk);
    endtask

    task automatic applyStimulus(input int t0, input int n, input int hw);
        waitUntil(t0);
        repeat (n) begin
            pulse_in = 1'b1;
            repeat (hw) @(negedge clk);
            pulse_in = 1'b0;
            repeat (hw) @(negedge clk);
        end
    endtask

    task automatic expectLatch(input int c, input logic [31:0] sv, input logic [31:0] wv, input logic ov);
        exp_t e;
        e.cycle    = c;
        e.sat_val  = sv;
        e.wrap_val = wv;
        e.ovf_val  = ov;
        sb.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_chars_sat"}, chars_s, 32'h0);
        checkOutput({tag, "_chars_wrap"}, chars_w, 32'h0);
        checkOutput({tag, "_stb"}, 32'(stb_s), 32'h0);
        checkOutput({tag, "_ovf"}, 32'(ovf_s), 32'h0);
    endtask

    // Scoreboard: every strobe from either instance must match the next queued latch
    always @(negedge clk) begin
        if (stb_s || stb_w) begin
            if (sb.size() == 0) begin
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("[TB] FAIL unexpected_strobe observed_cycle=%0d expected=none", cyc - base);
                end
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("stb_cycle", 32'(cyc - base), 32'(e.cycle));
                checkOutput("stb_both", {30'b0, stb_s, stb_w}, 32'h3);
                checkOutput("latch_sat", chars_s, e.sat_val);
                checkOutput("latch_wrap", chars_w, e.wrap_val);
                checkOutput("ovf_sat", 32'(ovf_s), 32'(e.ovf_val));
                checkOutput("ovf_wrap", 32'(ovf_w), 32'(e.ovf_val));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of windows
    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        pulse_in = 1'b0;
        clr      = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        checkOutput("reset_stb_wrap", 32'(stb_w), 32'h0);
        rst  = 1'b0;
        en   = 1'b1;
        base = cyc;

        expectLatch(G, 32'h37, 32'h37, 1'b0);
        applyStimulus(0, 37, 4);
        expectLatch(2*G, 32'h0, 32'h0, 1'b0);

        expectLatch(3*G, 32'h10, 32'h10, 1'b0);
        applyStimulus(3*G - 40, 10, 2);
        expectLatch(4*G, 32'h0, 32'h0, 1'b0);
        applyStimulus(4*G - 3, 1, 2);

        expectLatch(5*G + 50, 32'h6, 32'h6, 1'b0);
        applyStimulus(1300, 5, 4);
        waitUntil(1400);
        en = 1'b0;
        applyStimulus(1400, 12, 2);
        waitUntil(1450);
        en = 1'b1;

        applyStimulus(1700, 15, 2);
        waitUntil(1780);
        clr = 1'b1;
        waitUntil(1781);
        clr = 1'b0;
        checkAllZero("clr_mid");
        expectLatch(1781 + G, 32'h3, 32'h3, 1'b0);
        applyStimulus(1800, 3, 2);

        applyStimulus(2200, 4, 2);
        waitUntil(2101 + G - 1);
        clr = 1'b1;
        waitUntil(2101 + G);
        clr = 1'b0;
        checkAllZero("clr_term");
        expectLatch(2421 + G, 32'h2, 32'h2, 1'b0);
        applyStimulus(2500, 2, 2);

        expectLatch(2741 + G, 32'h9999_9999, 32'h0000_0001, OVF_EXP);
        waitUntil(2800);
        force dut_sat.acc  = 32'h9999_9998;
        force dut_wrap.acc = 32'h9999_9998;
        waitUntil(2801);
        release dut_sat.acc;
        release dut_wrap.acc;
        applyStimulus(2820, 3, 2);

        expectLatch(3061 + G, 32'h7, 32'h7, 1'b0);
        applyStimulus(3100, 7, 2);

        applyStimulus(3400, 5, 2);
        waitUntil(3500);
        rst = 1'b1;
        waitUntil(3501);
        rst = 1'b0;
        checkAllZero("rst_mid");
        checkOutput("rst_mid_chars_wrap_stb", 32'(stb_w), 32'h0);
        expectLatch(3501 + G, 32'h2, 32'h2, 1'b0);
        applyStimulus(3600, 2, 2);

        waitUntil(3501 + G + 10);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
